// File: rtl/decode_stage_if.sv
// Fetch/issue-facing signal bundle of the decode stage.
// The stage is the slave side; whoever feeds instructions and drains bundles holds the master side.
interface decode_stage_if #(
    parameter int INST_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 26,
    parameter int CNT_WIDTH      = 16
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [INST_WIDTH-1:0]     inst;
    logic                      out_valid;
    logic                      out_ready;
    logic                      use_rs1;
    logic                      use_rs2;
    logic                      use_rd;
    logic                      use_imm;
    logic                      read_mem;
    logic                      write_mem;
    logic [OPCODE_WIDTH-1:0]   decoded_opcode;
    logic [2:0]                inst_type;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [IMM_WIDTH-1:0]      imm;
    logic [VALUE_WIDTH-1:0]    value;
    logic                      illegal;
    logic [CNT_WIDTH-1:0]      bubble_count;

    modport slave (
        input  flush, in_valid, inst, out_ready,
        output in_ready, out_valid, use_rs1, use_rs2, use_rd, use_imm, read_mem, write_mem,
               decoded_opcode, inst_type, rs1_addr, rs2_addr, rd_addr, imm, value, illegal,
               bubble_count
    );

    modport master (
        output flush, in_valid, inst, out_ready,
        input  in_ready, out_valid, use_rs1, use_rs2, use_rd, use_imm, read_mem, write_mem,
               decoded_opcode, inst_type, rs1_addr, rs2_addr, rd_addr, imm, value, illegal,
               bubble_count
    );
endinterface

// File: rtl/decode_stage.sv
// DLX decode stage: decodes the incoming instruction and registers one bundle per accept,
// with back-pressure, flush, single-bubble load-use stall and a saturating bubble counter.
module decode_stage #(
    parameter int INST_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNC_WIDTH     = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16,
    parameter int VALUE_WIDTH    = 26,
    parameter int CNT_WIDTH      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam int RS1_LSB = INST_WIDTH - OPCODE_WIDTH - REG_ADDR_WIDTH;
    localparam int RS2_LSB = RS1_LSB - REG_ADDR_WIDTH;
    localparam int RDR_LSB = RS2_LSB - REG_ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'('h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'('h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'('h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'('h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_LHI   = OPCODE_WIDTH'('h0F);
    localparam logic [OPCODE_WIDTH-1:0] OP_JR    = OPCODE_WIDTH'('h12);
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR  = OPCODE_WIDTH'('h13);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'('h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'('h2B);
    localparam logic [FUNC_WIDTH-1:0]   F_ADD    = FUNC_WIDTH'('h20);
    localparam logic [FUNC_WIDTH-1:0]   F_SUB    = FUNC_WIDTH'('h22);
    localparam logic [FUNC_WIDTH-1:0]   F_AND    = FUNC_WIDTH'('h24);
    localparam logic [FUNC_WIDTH-1:0]   F_OR     = FUNC_WIDTH'('h25);
    localparam logic [FUNC_WIDTH-1:0]   F_XOR    = FUNC_WIDTH'('h26);
    localparam logic [REG_ADDR_WIDTH-1:0] LINK_REG = '1;

    typedef enum logic [2:0] {
        T_NOP, T_R, T_IALU, T_IMEM, T_J, T_JAL, T_JR, T_JALR
    } inst_type_e;

    // An all-zero bundle is exactly the NOP/bubble/reset value.
    typedef struct packed {
        logic                      use_rs1;
        logic                      use_rs2;
        logic                      use_rd;
        logic                      use_imm;
        logic                      read_mem;
        logic                      write_mem;
        logic                      illegal;
        logic [OPCODE_WIDTH-1:0]   op;
        inst_type_e                itype;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [VALUE_WIDTH-1:0]    field;
    } bundle_t;

    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNC_WIDTH-1:0]     func;
    logic [REG_ADDR_WIDTH-1:0] rs1_in, rs2_in, rdr_in;
    bundle_t                   dec_b;
    logic                      dec_is_lw;

    assign opcode = bus.inst[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign func   = bus.inst[FUNC_WIDTH-1:0];
    assign rs1_in = bus.inst[RS1_LSB +: REG_ADDR_WIDTH];
    assign rs2_in = bus.inst[RS2_LSB +: REG_ADDR_WIDTH];
    assign rdr_in = bus.inst[RDR_LSB +: REG_ADDR_WIDTH];

    always_comb begin
        dec_b       = '0;
        dec_b.field = bus.inst[VALUE_WIDTH-1:0];
        dec_is_lw   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    F_ADD, F_SUB, F_AND, F_OR, F_XOR: begin
                        dec_b.use_rs1 = 1'b1;
                        dec_b.use_rs2 = 1'b1;
                        dec_b.use_rd  = 1'b1;
                        dec_b.rd      = rdr_in;
                        dec_b.op      = OPCODE_WIDTH'(func);
                        dec_b.itype   = T_R;
                    end
                    default: dec_b.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LHI, OP_LW: begin
                dec_b.use_rs1  = (opcode != OP_LHI);
                dec_b.use_rd   = 1'b1;
                dec_b.use_imm  = 1'b1;
                dec_b.rd       = rs2_in;
                dec_b.op       = opcode;
                dec_b.read_mem = (opcode == OP_LW);
                dec_b.itype    = (opcode == OP_LW) ? T_IMEM : T_IALU;
                dec_is_lw      = (opcode == OP_LW);
            end
            OP_SW: begin
                dec_b.use_rs1   = 1'b1;
                dec_b.use_rs2   = 1'b1;
                dec_b.use_imm   = 1'b1;
                dec_b.write_mem = 1'b1;
                dec_b.op        = opcode;
                dec_b.itype     = T_IMEM;
            end
            OP_J, OP_JAL, OP_JR, OP_JALR: begin
                dec_b.use_rs1 = (opcode == OP_JR) || (opcode == OP_JALR);
                dec_b.use_rd  = (opcode == OP_JAL) || (opcode == OP_JALR);
                dec_b.rd      = dec_b.use_rd ? LINK_REG : '0;
                dec_b.op      = opcode;
                dec_b.itype   = (opcode == OP_J)   ? T_J   :
                                (opcode == OP_JAL) ? T_JAL :
                                (opcode == OP_JR)  ? T_JR  : T_JALR;
            end
            default: dec_b.illegal = 1'b1;
        endcase
    end

    logic                      valid_q, valid_d;
    bundle_t                   bundle_q, bundle_d;
    logic                      ld_pend_q, ld_pend_d;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic                      load_en, hazard, accept, bubble;

    // Hazard looks at the incoming decode so the dependent op waits exactly one slot.
    assign load_en = ~valid_q | bus.out_ready;
    assign hazard  = bus.in_valid & ld_pend_q &
                     ((dec_b.use_rs1 & (rs1_in == ld_rd_q)) | (dec_b.use_rs2 & (rs2_in == ld_rd_q)));
    assign accept  = bus.in_valid & bus.in_ready;
    assign bubble  = hazard & load_en & ~bus.flush;

    always_comb begin
        valid_d      = valid_q;
        bundle_d     = bundle_q;
        ld_pend_d    = ld_pend_q;
        ld_rd_d      = ld_rd_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            valid_d   = 1'b0;
            ld_pend_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            bundle_d  = dec_b;
            ld_pend_d = dec_is_lw & (dec_b.rd != '0);
            ld_rd_d   = dec_b.rd;
        end else if (bubble) begin
            valid_d   = 1'b1;
            bundle_d  = '0;
            ld_pend_d = 1'b0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end else if (valid_q & bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            bundle_q     <= '0;
            ld_pend_q    <= 1'b0;
            ld_rd_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            bundle_q     <= bundle_d;
            ld_pend_q    <= ld_pend_d;
            ld_rd_q      <= ld_rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.in_ready       = load_en & ~hazard & ~bus.flush;
    assign bus.out_valid      = valid_q;
    assign bus.use_rs1        = bundle_q.use_rs1;
    assign bus.use_rs2        = bundle_q.use_rs2;
    assign bus.use_rd         = bundle_q.use_rd;
    assign bus.use_imm        = bundle_q.use_imm;
    assign bus.read_mem       = bundle_q.read_mem;
    assign bus.write_mem      = bundle_q.write_mem;
    assign bus.illegal        = bundle_q.illegal;
    assign bus.decoded_opcode = bundle_q.op;
    assign bus.inst_type      = bundle_q.itype;
    assign bus.rd_addr        = bundle_q.rd;
    assign bus.rs1_addr       = bundle_q.field[RS1_LSB +: REG_ADDR_WIDTH];
    assign bus.rs2_addr       = bundle_q.field[RS2_LSB +: REG_ADDR_WIDTH];
    assign bus.imm            = bundle_q.field[IMM_WIDTH-1:0];
    assign bus.value          = bundle_q.field;
    assign bus.bubble_count   = bubble_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one task per scenario, inline checks, sampled on the falling edge.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decode_stage_if bus_if ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    function automatic logic [31:0] r_op(input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rd, input logic [15:0] im);
        return {op, rs1, rd, im};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus_if.flush = 1'b0; bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b1;
        bus_if.inst = 32'h0;
        repeat (2) @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus_if.out_valid); end
        tests++; if (bus_if.inst_type !== 3'd0) begin fails++; $display("FAIL rst_type: got %0d want 0", bus_if.inst_type); end
        tests++; if (bus_if.illegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %b want 0", bus_if.illegal); end
        tests++; if (bus_if.bubble_count !== 16'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus_if.bubble_count); end
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", bus_if.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_add();
        bus_if.inst = 32'h00221820; bus_if.in_valid = 1'b1;
        #1;
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready: got %b want 1", bus_if.in_ready); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b want 1", bus_if.out_valid); end
        tests++; if (bus_if.inst_type !== 3'd1) begin fails++; $display("FAIL add_type: got %0d want 1", bus_if.inst_type); end
        tests++; if ({bus_if.rs1_addr, bus_if.rs2_addr, bus_if.rd_addr} !== {5'd1, 5'd2, 5'd3}) begin
            fails++; $display("FAIL add_regs: got %0d/%0d/%0d want 1/2/3", bus_if.rs1_addr, bus_if.rs2_addr, bus_if.rd_addr); end
        tests++; if (bus_if.decoded_opcode !== 6'h20) begin fails++; $display("FAIL add_opc: got %h want 20", bus_if.decoded_opcode); end
        tests++; if ({bus_if.use_rs1, bus_if.use_rs2, bus_if.use_rd, bus_if.use_imm} !== 4'b1110) begin
            fails++; $display("FAIL add_uses: got %b want 1110", {bus_if.use_rs1, bus_if.use_rs2, bus_if.use_rd, bus_if.use_imm}); end
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b0) begin fails++; $display("FAIL add_drain: got %b want 0", bus_if.out_valid); end
        $display("[TB] test_add done");
    endtask

    task automatic test_load_use();
        bus_if.inst = i_op(6'h23, 5'd1, 5'd5, 16'd4); bus_if.in_valid = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.inst_type !== 3'd3 || bus_if.read_mem !== 1'b1 || bus_if.rd_addr !== 5'd5) begin
            fails++; $display("FAIL lu_lw: got type %0d rm %b rd %0d want 3 1 5", bus_if.inst_type, bus_if.read_mem, bus_if.rd_addr); end
        bus_if.inst = r_op(5'd5, 5'd2, 5'd6, 6'h20);
        #1;
        tests++; if (bus_if.in_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: got in_ready %b want 0", bus_if.in_ready); end
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b1 || bus_if.inst_type !== 3'd0 || bus_if.illegal !== 1'b0) begin
            fails++; $display("FAIL lu_bubble: got v %b type %0d ill %b want 1 0 0", bus_if.out_valid, bus_if.inst_type, bus_if.illegal); end
        tests++; if (bus_if.bubble_count !== 16'd1) begin fails++; $display("FAIL lu_count: got %0d want 1", bus_if.bubble_count); end
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL lu_resume: got in_ready %b want 1", bus_if.in_ready); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.inst_type !== 3'd1 || bus_if.rd_addr !== 5'd6 || bus_if.rs1_addr !== 5'd5) begin
            fails++; $display("FAIL lu_add: got type %0d rd %0d rs1 %0d want 1 6 5", bus_if.inst_type, bus_if.rd_addr, bus_if.rs1_addr); end
        tests++; if (bus_if.bubble_count !== 16'd1) begin fails++; $display("FAIL lu_count2: got %0d want 1", bus_if.bubble_count); end
        @(negedge clk);
        $display("[TB] test_load_use done");
    endtask

    task automatic test_lw_r0();
        bus_if.inst = i_op(6'h23, 5'd1, 5'd0, 16'd0); bus_if.in_valid = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.rd_addr !== 5'd0 || bus_if.inst_type !== 3'd3) begin
            fails++; $display("FAIL r0_lw: got rd %0d type %0d want 0 3", bus_if.rd_addr, bus_if.inst_type); end
        bus_if.inst = r_op(5'd0, 5'd2, 5'd7, 6'h20);
        #1;
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL r0_no_stall: got in_ready %b want 1", bus_if.in_ready); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.inst_type !== 3'd1 || bus_if.rd_addr !== 5'd7) begin
            fails++; $display("FAIL r0_add: got type %0d rd %0d want 1 7", bus_if.inst_type, bus_if.rd_addr); end
        tests++; if (bus_if.bubble_count !== 16'd1) begin fails++; $display("FAIL r0_count: got %0d want 1", bus_if.bubble_count); end
        @(negedge clk);
        $display("[TB] test_lw_r0 done");
    endtask

    task automatic test_backpressure();
        bus_if.out_ready = 1'b0;
        bus_if.inst = i_op(6'h2B, 5'd2, 5'd7, 16'd8); bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.inst = r_op(5'd1, 5'd1, 5'd1, 6'h24);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus_if.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus_if.in_ready); end
            tests++; if (bus_if.out_valid !== 1'b1 || bus_if.inst_type !== 3'd3 || bus_if.use_rs2 !== 1'b1 ||
                         bus_if.rs2_addr !== 5'd7 || bus_if.write_mem !== 1'b1 || bus_if.rd_addr !== 5'd0 ||
                         bus_if.use_rd !== 1'b0 || bus_if.imm !== 16'd8 || bus_if.rs1_addr !== 5'd2) begin
                fails++; $display("FAIL bp_hold[%0d]: got v %b type %0d rs2 %0d wm %b rd %0d imm %0d want 1 3 7 1 0 8",
                                  i, bus_if.out_valid, bus_if.inst_type, bus_if.rs2_addr, bus_if.write_mem, bus_if.rd_addr, bus_if.imm); end
            @(negedge clk);
        end
        bus_if.out_ready = 1'b1;
        #1;
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got in_ready %b want 1", bus_if.in_ready); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.inst_type !== 3'd1 || bus_if.decoded_opcode !== 6'h24) begin
            fails++; $display("FAIL bp_next: got type %0d opc %h want 1 24", bus_if.inst_type, bus_if.decoded_opcode); end
        @(negedge clk);
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_illegal();
        bus_if.inst = {6'h3F, 26'h0}; bus_if.in_valid = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b1 || bus_if.illegal !== 1'b1 || bus_if.inst_type !== 3'd0 || bus_if.decoded_opcode !== 6'h0) begin
            fails++; $display("FAIL ill_op: got v %b ill %b type %0d opc %h want 1 1 0 00", bus_if.out_valid, bus_if.illegal, bus_if.inst_type, bus_if.decoded_opcode); end
        bus_if.inst = i_op(6'h08, 5'd0, 5'd4, 16'h1234);
        @(negedge clk);
        tests++; if (bus_if.imm !== 16'h1234 || bus_if.inst_type !== 3'd2 || bus_if.rd_addr !== 5'd4 ||
                     bus_if.use_imm !== 1'b1 || bus_if.illegal !== 1'b0 || bus_if.decoded_opcode !== 6'h08) begin
            fails++; $display("FAIL ill_addi: got imm %h type %0d rd %0d ill %b want 1234 2 4 0", bus_if.imm, bus_if.inst_type, bus_if.rd_addr, bus_if.illegal); end
        bus_if.inst = r_op(5'd1, 5'd2, 5'd3, 6'h21);
        @(negedge clk);
        tests++; if (bus_if.illegal !== 1'b1 || bus_if.inst_type !== 3'd0 || bus_if.use_rd !== 1'b0 || bus_if.rd_addr !== 5'd0) begin
            fails++; $display("FAIL ill_func: got ill %b type %0d use_rd %b rd %0d want 1 0 0 0", bus_if.illegal, bus_if.inst_type, bus_if.use_rd, bus_if.rd_addr); end
        bus_if.inst = i_op(6'h0F, 5'd7, 5'd9, 16'hBEEF);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.use_rs1 !== 1'b0 || bus_if.rd_addr !== 5'd9 || bus_if.inst_type !== 3'd2 || bus_if.imm !== 16'hBEEF) begin
            fails++; $display("FAIL lhi: got use_rs1 %b rd %0d type %0d imm %h want 0 9 2 beef", bus_if.use_rs1, bus_if.rd_addr, bus_if.inst_type, bus_if.imm); end
        @(negedge clk);
        $display("[TB] test_illegal done");
    endtask

    task automatic test_jumps();
        bus_if.inst = {6'h03, 26'h0123456}; bus_if.in_valid = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.inst_type !== 3'd5 || bus_if.rd_addr !== 5'd31 || bus_if.use_rd !== 1'b1 || bus_if.value !== 26'h0123456) begin
            fails++; $display("FAIL jal: got type %0d rd %0d val %h want 5 31 0123456", bus_if.inst_type, bus_if.rd_addr, bus_if.value); end
        bus_if.inst = {6'h13, 5'd9, 21'd0};
        @(negedge clk);
        tests++; if (bus_if.inst_type !== 3'd7 || bus_if.rs1_addr !== 5'd9 || bus_if.use_rs1 !== 1'b1 || bus_if.rd_addr !== 5'd31) begin
            fails++; $display("FAIL jalr: got type %0d rs1 %0d rd %0d want 7 9 31", bus_if.inst_type, bus_if.rs1_addr, bus_if.rd_addr); end
        bus_if.inst = {6'h02, 26'h3FFFFFF};
        @(negedge clk);
        tests++; if (bus_if.inst_type !== 3'd4 || bus_if.use_rd !== 1'b0 || bus_if.rd_addr !== 5'd0 || bus_if.value !== 26'h3FFFFFF) begin
            fails++; $display("FAIL j: got type %0d use_rd %b rd %0d val %h want 4 0 0 3ffffff", bus_if.inst_type, bus_if.use_rd, bus_if.rd_addr, bus_if.value); end
        bus_if.inst = {6'h12, 5'd4, 21'd0};
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.inst_type !== 3'd6 || bus_if.rs1_addr !== 5'd4 || bus_if.use_rd !== 1'b0) begin
            fails++; $display("FAIL jr: got type %0d rs1 %0d use_rd %b want 6 4 0", bus_if.inst_type, bus_if.rs1_addr, bus_if.use_rd); end
        @(negedge clk);
        $display("[TB] test_jumps done");
    endtask

    task automatic test_flush();
        bus_if.inst = i_op(6'h23, 5'd1, 5'd5, 16'd0); bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.inst = r_op(5'd5, 5'd2, 5'd6, 6'h22); bus_if.flush = 1'b1;
        #1;
        tests++; if (bus_if.in_ready !== 1'b0) begin fails++; $display("FAIL fl_in_ready: got %b want 0", bus_if.in_ready); end
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b0) begin fails++; $display("FAIL fl_valid: got %b want 0", bus_if.out_valid); end
        tests++; if (bus_if.bubble_count !== 16'd1) begin fails++; $display("FAIL fl_count: got %0d want 1", bus_if.bubble_count); end
        bus_if.flush = 1'b0;
        #1;
        tests++; if (bus_if.in_ready !== 1'b1) begin fails++; $display("FAIL fl_no_hazard: got in_ready %b want 1", bus_if.in_ready); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.out_valid !== 1'b1 || bus_if.inst_type !== 3'd1 || bus_if.rd_addr !== 5'd6 || bus_if.decoded_opcode !== 6'h22) begin
            fails++; $display("FAIL fl_dep: got v %b type %0d rd %0d opc %h want 1 1 6 22", bus_if.out_valid, bus_if.inst_type, bus_if.rd_addr, bus_if.decoded_opcode); end
        tests++; if (bus_if.bubble_count !== 16'd1) begin fails++; $display("FAIL fl_count2: got %0d want 1", bus_if.bubble_count); end
        @(negedge clk);
        $display("[TB] test_flush done");
    endtask

    task automatic test_hazard_backpressure();
        bus_if.out_ready = 1'b0;
        bus_if.inst = i_op(6'h23, 5'd1, 5'd8, 16'd0); bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.inst = i_op(6'h2B, 5'd3, 5'd8, 16'd12);
        repeat (2) begin
            #1;
            tests++; if (bus_if.in_ready !== 1'b0 || bus_if.inst_type !== 3'd3 || bus_if.read_mem !== 1'b1 || bus_if.bubble_count !== 16'd1) begin
                fails++; $display("FAIL hb_hold: got rdy %b type %0d rm %b cnt %0d want 0 3 1 1", bus_if.in_ready, bus_if.inst_type, bus_if.read_mem, bus_if.bubble_count); end
            @(negedge clk);
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b1 || bus_if.inst_type !== 3'd0 || bus_if.bubble_count !== 16'd2) begin
            fails++; $display("FAIL hb_bubble: got v %b type %0d cnt %0d want 1 0 2", bus_if.out_valid, bus_if.inst_type, bus_if.bubble_count); end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.write_mem !== 1'b1 || bus_if.rs2_addr !== 5'd8 || bus_if.bubble_count !== 16'd2) begin
            fails++; $display("FAIL hb_sw: got wm %b rs2 %0d cnt %0d want 1 8 2", bus_if.write_mem, bus_if.rs2_addr, bus_if.bubble_count); end
        @(negedge clk);
        $display("[TB] test_hazard_backpressure done");
    endtask

    task automatic test_reset_mid();
        bus_if.out_ready = 1'b0;
        bus_if.inst = r_op(5'd1, 5'd2, 5'd3, 6'h25); bus_if.in_valid = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        tests++; if (bus_if.out_valid !== 1'b1 || bus_if.decoded_opcode !== 6'h25) begin
            fails++; $display("FAIL rm_held: got v %b opc %h want 1 25", bus_if.out_valid, bus_if.decoded_opcode); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus_if.out_valid !== 1'b0 || bus_if.bubble_count !== 16'd0 || bus_if.inst_type !== 3'd0 || bus_if.rd_addr !== 5'd0) begin
            fails++; $display("FAIL rm_reset: got v %b cnt %0d type %0d rd %0d want 0 0 0 0", bus_if.out_valid, bus_if.bubble_count, bus_if.inst_type, bus_if.rd_addr); end
        @(negedge clk);
        rst_n = 1'b1; bus_if.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            fails++; $display("FAIL rm_after: got v %b rdy %b want 0 1", bus_if.out_valid, bus_if.in_ready); end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_lw_r0();
        test_backpressure();
        test_illegal();
        test_jumps();
        test_flush();
        test_hazard_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
